// File: rtl/err_event_arbiter.sv
// Serialises error events from NUM_SRC checkers onto one valid/ready stream.
// Round-robin grant, per-source saturating counters, and a HALT latch on fatal codes.
module err_event_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CODE_W  = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*CODE_W-1:0]  src_code,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       out_valid,
  output logic [$clog2(NUM_SRC)-1:0] out_src_id,
  output logic [CODE_W-1:0]          out_code,
  input  logic                       out_ready,
  input  logic                       resume,
  input  logic                       clr_counts,
  input  logic [$clog2(NUM_SRC)-1:0] cnt_sel,
  output logic [CNT_W-1:0]           cnt_value,
  output logic                       halted,
  output logic                       any_error
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_src_id_q, out_src_id_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  cnt_d [NUM_SRC];

  logic              slot_free;
  logic              grant_ok;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [CODE_W-1:0] grant_code;
  logic              accept;
  logic              acc_fatal;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    return ID_W'((32'(base) + off) % NUM_SRC);
  endfunction

  // Grant is withheld during reset so src_ready reads zero while rst_n is low
  assign slot_free = !out_valid_q || out_ready;
  assign grant_ok  = rst_n && (state_q == ST_RUN) && slot_free;

  // Round-robin search starting at rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!grant_found && src_valid[wrap_idx(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  assign grant_code = src_code[32'(grant_idx)*CODE_W +: CODE_W];
  assign accept     = grant_ok && grant_found;
  assign acc_fatal  = accept && grant_code[CODE_W-1];

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[grant_idx] = 1'b1;
  end

  // FSM next state, pointer and output slot
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_src_id_d = out_src_id_q;
    out_code_d   = out_code_q;

    case (state_q)
      ST_RUN:  if (acc_fatal) state_d = ST_HALT;
      ST_HALT: if (resume)    state_d = ST_RUN;
    endcase

    if (accept) begin
      out_valid_d  = 1'b1;
      out_src_id_d = grant_idx;
      out_code_d   = grant_code;
      rr_ptr_d     = wrap_idx(grant_idx, 1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_comb begin
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_counts) begin
        cnt_d[k] = '0;
      end else if (accept && (grant_idx == ID_W'(k)) && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_src_id_q <= '0;
      out_code_q   <= '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_src_id_q <= out_src_id_d;
      out_code_q   <= out_code_d;
      for (int unsigned k = 0; k < NUM_SRC; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Counter readback; selects beyond NUM_SRC read as zero
  always_comb begin
    cnt_value = '0;
    any_error = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(cnt_sel) == k) cnt_value = cnt_q[k];
      if (cnt_q[k] != '0)    any_error = 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_src_id = out_src_id_q;
  assign out_code   = out_code_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_err_event_arbiter.sv
// Self-checking bench for err_event_arbiter: vector table plus scoreboard of
// expected output events, with hand-written backpressure/fatal/saturation/reset sequences.
module tb_err_event_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [31:0] src_code;
  logic [3:0]  src_ready;
  logic        out_valid;
  logic [1:0]  out_src_id;
  logic [7:0]  out_code;
  logic        out_ready;
  logic        resume;
  logic        clr_counts;
  logic [1:0]  cnt_sel;
  logic [7:0]  cnt_value;
  logic        halted;
  logic        any_error;

  err_event_arbiter #(.NUM_SRC(4), .CODE_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_code   (src_code),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_src_id (out_src_id),
    .out_code   (out_code),
    .out_ready  (out_ready),
    .resume     (resume),
    .clr_counts (clr_counts),
    .cnt_sel    (cnt_sel),
    .cnt_value  (cnt_value),
    .halted     (halted),
    .any_error  (any_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic [3:0]  v;
    logic [31:0] codes;
    logic        ordy;
    logic [3:0]  exp_rdy;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] code;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   sel_rot  = 0;
  exp_t exp_q[$];
  logic m_halt;
  int   m_rr;
  int   m_cnt[4];
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] codes4(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic model_reset();
    m_halt = 1'b0;
    m_rr   = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    exp_q.delete();
  endtask

  // Entered at posedge+1; samples at the falling edge, then advances one cycle.
  task automatic step(input logic [3:0] v, input logic [31:0] codes, input logic ordy,
                      input logic res, input logic clr, output logic [3:0] rdy_seen);
    logic [3:0] m_rdy;
    int         g;
    logic       m_any;
    exp_t       e;
    src_valid  = v;
    src_code   = codes;
    out_ready  = ordy;
    resume     = res;
    clr_counts = clr;
    cnt_sel    = 2'(sel_rot % 4);
    sel_rot++;
    #4;
    m_rdy = '0;
    g     = -1;
    if (!m_halt && (exp_q.size() == 0 || ordy)) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && v[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      end
    end
    if (g >= 0) m_rdy[g] = 1'b1;
    m_any = 1'b0;
    for (int k = 0; k < 4; k++) if (m_cnt[k] != 0) m_any = 1'b1;

    rdy_seen = src_ready;
    chk("src_ready", 32'(src_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_src_id", 32'(out_src_id), 32'(exp_q[0].id));
      chk("out_code", 32'(out_code), 32'(exp_q[0].code));
    end
    chk("halted", 32'(halted), 32'(m_halt));
    chk("any_error", 32'(any_error), 32'(m_any));
    chk("cnt_value", 32'(cnt_value), 32'(m_cnt[cnt_sel]));

    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (g >= 0) begin
      e.id   = 2'(g);
      e.code = codes[g*8 +: 8];
      exp_q.push_back(e);
      if (m_cnt[g] < 255) m_cnt[g]++;
      m_rr = (g + 1) % 4;
      if (e.code[7]) m_halt = 1'b1;
    end else if (m_halt && res) begin
      m_halt = 1'b0;
    end
    if (clr) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    @(posedge clk);
    #1;
    resume     = 1'b0;
    clr_counts = 1'b0;
  endtask

  task automatic do_reset();
    src_valid = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input int idx, input int exp);
    cnt_sel = 2'(idx);
    #1;
    chk($sformatf("cnt[%0d]", idx), 32'(cnt_value), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r;
    logic [31:0] cf;
    logic [31:0] cb;
    logic [31:0] cfat;
    logic [31:0] cs;

    cf = codes4(8'h01, 8'h02, 8'h03, 8'h04);
    tbl[0]  = '{1'b0, 4'b0100, codes4(8'h00, 8'h00, 8'h13, 8'h00), 1'b1, 4'b0100};
    tbl[1]  = '{1'b0, 4'b0000, codes4(8'h00, 8'h00, 8'h13, 8'h00), 1'b1, 4'b0000};
    tbl[2]  = '{1'b1, 4'b1111, cf, 1'b1, 4'b0001};
    tbl[3]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b0010};
    tbl[4]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b0100};
    tbl[5]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b1000};
    tbl[6]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b0001};
    tbl[7]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b0010};
    tbl[8]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b0100};
    tbl[9]  = '{1'b0, 4'b1111, cf, 1'b1, 4'b1000};
    tbl[10] = '{1'b0, 4'b0000, cf, 1'b1, 4'b0000};

    rst_n      = 1'b0;
    src_valid  = '0;
    src_code   = '0;
    out_ready  = 1'b0;
    resume     = 1'b0;
    clr_counts = 1'b0;
    cnt_sel    = '0;
    model_reset();
    #2;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_src_id", 32'(out_src_id), 0);
    chk("rst out_code", 32'(out_code), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst any_error", 32'(any_error), 0);
    chk("rst src_ready", 32'(src_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic and fairness vectors
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) do_reset();
      step(tbl[i].v, tbl[i].codes, tbl[i].ordy, 1'b0, 1'b0, r);
      chk($sformatf("vec%0d src_ready", i), 32'(r), 32'(tbl[i].exp_rdy));
    end
    for (int k = 0; k < 4; k++) chk_cnt(k, 2);

    // Backpressure: hold for 5 cycles, then drain back-to-back
    cb = codes4(8'h11, 8'h21, 8'h00, 8'h33);
    step(4'b0001, cb, 1'b1, 1'b0, 1'b0, r);
    for (int i = 0; i < 5; i++) begin
      step(4'b1010, cb, 1'b0, 1'b0, 1'b0, r);
      chk("bp src_ready", 32'(r), 0);
      chk("bp out_src_id", 32'(out_src_id), 0);
      chk("bp out_code", 32'(out_code), 32'h11);
    end
    step(4'b1010, cb, 1'b1, 1'b0, 1'b0, r);
    chk("bp rel grant1", 32'(r), 32'b0010);
    step(4'b1000, cb, 1'b1, 1'b0, 1'b0, r);
    chk("bp rel grant3", 32'(r), 32'b1000);
    chk("bp rel code1", 32'(out_code), 32'h33);
    step(4'b0000, cb, 1'b1, 1'b0, 1'b0, r);

    // Fatal event halts new accepts until resume
    cfat = codes4(8'h80, 8'h22, 8'h00, 8'h00);
    step(4'b0011, cfat, 1'b1, 1'b0, 1'b0, r);
    chk("fatal grant0", 32'(r), 32'b0001);
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, cfat, 1'b1, 1'b0, 1'b0, r);
      chk("halt src_ready", 32'(r), 0);
      chk("halt halted", 32'(halted), 1);
    end
    step(4'b0010, cfat, 1'b1, 1'b1, 1'b0, r);
    chk("resume cycle src_ready", 32'(r), 0);
    chk("resume halted", 32'(halted), 0);
    step(4'b0010, cfat, 1'b1, 1'b0, 1'b0, r);
    chk("post resume grant1", 32'(r), 32'b0010);
    step(4'b0000, cfat, 1'b1, 1'b0, 1'b0, r);

    // Saturation at 255, then clear coincident with an accept
    cs = codes4(8'h00, 8'h00, 8'h00, 8'h05);
    for (int i = 0; i < 300; i++) step(4'b1000, cs, 1'b1, 1'b0, 1'b0, r);
    step(4'b0000, cs, 1'b1, 1'b0, 1'b0, r);
    chk_cnt(3, 255);
    step(4'b1000, cs, 1'b1, 1'b0, 1'b1, r);
    chk("clr accept", 32'(r), 32'b1000);
    step(4'b0000, cs, 1'b1, 1'b0, 1'b0, r);
    chk_cnt(3, 0);
    chk("clr any_error", 32'(any_error), 0);

    // Async reset mid-stream with an event held
    step(4'b1111, cf, 1'b0, 1'b0, 1'b0, r);
    chk("pre-rst out_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst src_ready", 32'(src_ready), 0);
    chk("arst out_code", 32'(out_code), 0);
    chk("arst out_src_id", 32'(out_src_id), 0);
    chk("arst any_error", 32'(any_error), 0);
    chk("arst halted", 32'(halted), 0);
    model_reset();
    src_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1111, cf, 1'b1, 1'b0, 1'b0, r);
    chk("post-rst grant0", 32'(r), 32'b0001);
    step(4'b0000, cf, 1'b1, 1'b0, 1'b0, r);
    step(4'b0000, cf, 1'b1, 1'b0, 1'b0, r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/err_event_arbiter.md
Name: err_event_arbiter

Overview:
- Collects error events from NUM_SRC independent checkers and serialises them onto one valid/ready event stream for the logging or reporting sink.
- Arbitrates between sources round-robin and keeps per-source saturating event counters.
- Latches into a HALT state on any fatal event; software or the testbench clears HALT with `resume`.
- Sits between the assertion/checker monitors and the error log or interrupt logic.

Parameters:
NUM_SRC, 4, number of error sources (2..16)
CODE_W, 8, error code width; MSB set marks the event as fatal
CNT_W, 8, per-source event counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
src_valid  input  NUM_SRC  per-source event request; held until accepted
src_code  input  NUM_SRC*CODE_W  per-source code; source i at bits [i*CODE_W +: CODE_W]
src_ready  output  NUM_SRC  one-hot acceptance (combinational)
out_valid  output  1  event available to sink
out_src_id  output  $clog2(NUM_SRC)  source index of the presented event
out_code  output  CODE_W  code of the presented event
out_ready  input  1  sink accepts event
resume  input  1  single-cycle pulse; leaves HALT
clr_counts  input  1  single-cycle pulse; zeroes all counters
cnt_sel  input  $clog2(NUM_SRC)  counter readback select
cnt_value  output  CNT_W  count for cnt_sel (combinational read)
halted  output  1  high while in HALT
any_error  output  1  high when any counter is nonzero

Behaviour:
- Reset (rst_n low, async): state=RUN, rr_ptr=0, out_valid=0, out_src_id=0, out_code=0, all counters=0, halted=0, any_error=0, src_ready=0. Mid-operation reset discards the held output event without handshake.
- FSM states:
  - RUN -> HALT on any accept whose code MSB is 1.
  - HALT -> RUN on a `resume` pulse.
  - In HALT, with `resume` high and a fatal accept impossible, the next state is RUN.
  - `halted` = (state==HALT), registered.
- Output slot free = !out_valid || out_ready (a same-cycle drain counts as free).
- Grant:
  - Only when state==RUN and the output slot is free.
  - Select the first i with src_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - src_ready = onehot(i); otherwise src_ready = 0.
- Accept (src_valid[i] && src_ready[i] at a posedge):
  - Register out_valid=1, out_src_id=i, out_code=src_code[i].
  - rr_ptr <= (i+1) mod NUM_SRC.
  - rr_ptr is unchanged when nothing is accepted.
- Latency: one cycle, accept edge N -> out_valid visible after edge N.
- Throughput: one event per cycle when out_ready stays high.
- Output hold: while out_valid && !out_ready, out_src_id and out_code hold stable and src_ready = 0.
- Output clear: out_valid falls after a handshake edge only if no new accept occurs on that same edge.
- A fatal event is still presented and drained normally; HALT blocks only new accepts.
- Counters:
  - On accept from source i, cnt[i] increments and saturates at 2^CNT_W-1 (no wrap).
  - clr_counts has priority over a same-cycle increment, so the result is 0.
  - clr_counts does not affect the FSM or the output slot.
- any_error = OR of (cnt[k] != 0), combinational from counter registers.
- cnt_value = cnt[cnt_sel]. A cnt_sel >= NUM_SRC returns 0.
- Source contract: a source must keep src_valid and src_code stable until accepted. The block does not check this.

Test Plan:
- Basic: reset, src_valid[2]=1 with code 8'h13, out_ready=1.
  -> src_ready[2] high that cycle; next cycle out_valid=1, out_src_id=2, out_code=8'h13; cnt[2]=1; any_error=1.
- Fairness: all four sources valid continuously with codes 8'h01..8'h04, out_ready=1.
  -> accepted order 0,1,2,3,0,1,... one per cycle; after 8 cycles every cnt=2.
- Backpressure: one event accepted, out_ready=0 for 5 cycles while src 1 and src 3 stay valid.
  -> out_* stable and src_ready=0 for all 5 cycles; on release, events drain back-to-back.
- Fatal: src 0 sends 8'h80 while src 1 is valid.
  -> 8'h80 presented; halted=1 on the next cycle; src 1 not accepted for 10 cycles.
  -> A `resume` pulse leads to src 1 accepted on the following cycle and halted=0.
- Saturation and clear, with CNT_W=8:
  - 300 non-fatal events from src 3 -> cnt[3]=255.
  - clr_counts pulsed on the same cycle as an accept from src 3 -> cnt[3]=0 and any_error=0.
- Async reset: assert rst_n low mid-stream with out_valid=1, at a non-clock time.
  -> all outputs clear immediately; after release, rr_ptr=0, so src 0 wins a full contention.
